// File: rtl/mmio_switch_led_port.sv
// Bus slave for board switches (synchronized, optionally debounced) and LEDs.
// Optional feature macro: DEBOUNCE_EN (default build follows sync2 directly).
module mmio_switch_led_port #(
  parameter int          SW_W         = 16,
  parameter int          DEBOUNCE_CYC = 50000,
  parameter logic [29:0] SWITCH_ADDR  = 30'h0,
  parameter logic [29:0] LED_ADDR     = 30'h4,
  parameter logic [29:0] STATUS_ADDR  = 30'h8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [29:0]     memAddress,
  input  logic            readEnable,
  input  logic            writeEnable,
  input  logic [31:0]     writeData,
  output logic [31:0]     readData,
  input  logic [SW_W-1:0] sw,
  output logic [SW_W-1:0] led,
  output logic            bus_error
);

  logic [SW_W-1:0] sync1;
  logic [SW_W-1:0] sync2;
  logic [SW_W-1:0] deb;
  logic [15:0]     change_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw;
      sync2 <= sync1;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int DW =
    (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYC - 1);

  logic [SW_W-1:0] cand;
  logic [DW-1:0]   dcnt;

  // A candidate must match sync2 for DEBOUNCE_CYC cycles before acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand       <= '0;
      dcnt       <= '0;
      deb        <= '0;
      change_cnt <= '0;
    end else if (sync2 != cand) begin
      cand <= sync2;
      dcnt <= '0;
    end else if (dcnt == DMAX && cand != deb) begin
      deb        <= cand;
      change_cnt <= change_cnt + 16'd1;
    end else if (dcnt != DMAX) begin
      dcnt <= dcnt + 1'b1;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      deb        <= '0;
      change_cnt <= '0;
    end else begin
      deb <= sync2;
      if (sync2 != deb)
        change_cnt <= change_cnt + 16'd1;
    end
  end
`endif

  logic hit_sw;
  logic hit_led;
  logic hit_st;
  logic rd_bad;
  logic wr_bad;
  logic [31:0] rd_mux;

  assign hit_sw  = (memAddress == SWITCH_ADDR);
  assign hit_led = (memAddress == LED_ADDR);
  assign hit_st  = (memAddress == STATUS_ADDR);
  assign rd_bad  = readEnable & ~(hit_sw | hit_led | hit_st);
  assign wr_bad  = writeEnable & ~hit_led;

  always_comb begin
    rd_mux = 32'h0;
    unique case (1'b1)
      hit_sw:  rd_mux = 32'(deb);
      hit_led: rd_mux = 32'(led);
      hit_st:  rd_mux = {change_cnt, 15'd0, |deb};
      default: rd_mux = 32'h0;
    endcase
  end

  // Read samples led before a same-edge write lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      readData  <= '0;
      led       <= '0;
      bus_error <= 1'b0;
    end else begin
      bus_error <= rd_bad | wr_bad;
      if (readEnable)
        readData <= rd_mux;
      if (writeEnable && hit_led)
        led <= writeData[SW_W-1:0];
    end
  end

  logic unused_bits;
  assign unused_bits =
    (^writeData[31:SW_W]) ^ (DEBOUNCE_CYC == 0);

endmodule

// File: tb/tb_mmio_switch_led_port.sv
// Directed bench for mmio_switch_led_port; DEBOUNCE_CYC=4.
// Expectations follow the DEBOUNCE_EN setting of the build.
module tb_mmio_switch_led_port;

  logic        clk = 1'b0;
  logic        rst;
  logic [29:0] memAddress;
  logic        readEnable;
  logic        writeEnable;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic [15:0] sw;
  logic [15:0] led;
  logic        bus_error;

  int errors = 0;
  int checks = 0;

`ifdef DEBOUNCE_EN
  localparam logic [31:0] ST_AFTER_GLITCH = 32'h0002_0000;
`else
  localparam logic [31:0] ST_AFTER_GLITCH = 32'h0004_0000;
`endif

  mmio_switch_led_port #(
    .SW_W(16),
    .DEBOUNCE_CYC(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .memAddress(memAddress),
    .readEnable(readEnable),
    .writeEnable(writeEnable),
    .writeData(writeData),
    .readData(readData),
    .sw(sw),
    .led(led),
    .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [29:0] a);
    memAddress = a;
    readEnable = 1'b1;
    step(1);
    readEnable = 1'b0;
  endtask

  task automatic wr(input logic [29:0] a, input logic [31:0] d);
    memAddress  = a;
    writeData   = d;
    writeEnable = 1'b1;
    step(1);
    writeEnable = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    memAddress = '0;
    readEnable = 1'b0;
    writeEnable = 1'b0;
    writeData = '0;
    sw = '0;
    step(2);
    check("rst_rdata", readData, 32'h0);
    check("rst_led", 32'(led), 32'h0);
    check("rst_berr", 32'(bus_error), 32'h0);
    rst = 1'b0;
    rd(30'h8);
    check("status_init", readData, 32'h0);
    check("status_berr", 32'(bus_error), 32'h0);

    sw = 16'h0005;
    step(10);
    rd(30'h0);
    check("sw_5", readData, 32'h0000_0005);
    rd(30'h8);
    check("status_5", readData, 32'h0001_0001);
    step(2);
    check("rdata_hold", readData, 32'h0001_0001);

    sw = 16'h0000;
    step(10);
    sw = 16'h00FF;
    step(2);
    sw = 16'h0000;
    step(10);
    rd(30'h0);
    check("glitch_sw", readData, 32'h0);
    rd(30'h8);
    check("glitch_status", readData, ST_AFTER_GLITCH);

    wr(30'h4, 32'hDEAD_0003);
    check("led_wr", 32'(led), 32'h3);
    check("led_wr_berr", 32'(bus_error), 32'h0);
    rd(30'h4);
    check("led_rd", readData, 32'h3);

    wr(30'h0, 32'h0000_FFFF);
    check("wr_sw_berr", 32'(bus_error), 32'h1);
    check("wr_sw_led", 32'(led), 32'h3);
    step(1);
    check("berr_pulse", 32'(bus_error), 32'h0);
    wr(30'h8, 32'h0000_1234);
    check("wr_st_berr", 32'(bus_error), 32'h1);
    check("wr_st_led", 32'(led), 32'h3);
    rd(30'h10);
    check("rd_bad_data", readData, 32'h0);
    check("rd_bad_berr", 32'(bus_error), 32'h1);
    step(1);
    check("rd_bad_end", 32'(bus_error), 32'h0);

    memAddress  = 30'h4;
    writeData   = 32'h7;
    writeEnable = 1'b1;
    readEnable  = 1'b1;
    step(1);
    writeEnable = 1'b0;
    readEnable  = 1'b0;
    check("rw_rdata", readData, 32'h3);
    check("rw_led", 32'(led), 32'h7);
    check("rw_berr", 32'(bus_error), 32'h0);

    wr(30'h4, 32'h0000_0009);
    memAddress  = 30'h14;
    writeEnable = 1'b1;
    readEnable  = 1'b1;
    step(1);
    writeEnable = 1'b0;
    readEnable  = 1'b0;
    check("rw_bad_berr", 32'(bus_error), 32'h1);
    check("rw_bad_data", readData, 32'h0);
    check("rw_bad_led", 32'(led), 32'h9);
    step(1);
    check("rw_bad_end", 32'(bus_error), 32'h0);

    sw = 16'h000A;
    step(4);
    memAddress = 30'h4;
    readEnable = 1'b1;
    rst = 1'b1;
    step(1);
    readEnable = 1'b0;
    rst = 1'b0;
    check("mid_rst_rdata", readData, 32'h0);
    check("mid_rst_led", 32'(led), 32'h0);
    check("mid_rst_berr", 32'(bus_error), 32'h0);
    rd(30'h8);
    check("mid_rst_status", readData, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
